mix_columns_seq: RTL and testbench
==================================

# mix_columns_seq

Sequential AES MixColumns engine that sits directly downstream of the GF(2^8) multiply arithmetic. It accepts a 128-bit AES state over a valid/ready handshake and multiplies each column by the fixed MixColumns matrix in GF(2^8) mod x^8+x^4+x^3+x+1 (0x11B). It processes COLS_PER_CYCLE columns per clock and returns the result over a second valid/ready handshake. The same block serves as the round-datapath stage and as a bench reference model.

## Interface
- COLS_PER_CYCLE, default 1: columns processed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input state valid.
- in_ready  out  1  engine can accept a state.
- in_data  in  128  input state. Byte 0 is [127:120]. Column c is bytes 4c..4c+3 = [127-32c -: 32], with row 0 in the MSB byte.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  128  result state, same byte order as in_data.
- busy  out  1  high in BUSY or DONE.
- inv_i  in  1  select InvMixColumns. The port exists only with MIX_COLUMNS_INV_EN.

## Operation
- FSM states are IDLE, BUSY and DONE. K = 4/COLS_PER_CYCLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data (and inv_i), clear column counter, go to BUSY.
- BUSY:
  - in_ready=0.
  - Each clock, transform columns [cnt*COLS_PER_CYCLE +: COLS_PER_CYCLE] and write them into the result register in place.
  - cnt increments by 1 per clock. After the K-th BUSY clock, go to DONE.
- DONE:
  - out_valid=1 and out_data is stable.
  - Hold until out_ready=1, then go to IDLE.
  - in_ready stays 0 in DONE, so no same-cycle accept after output.
- Forward transform, per column (a0..a3) -> (b0..b3), with ⊕ as XOR:
  - b0=2a0⊕3a1⊕a2⊕a3
  - b1=a0⊕2a1⊕3a2⊕a3
  - b2=a0⊕a1⊕2a2⊕3a3
  - b3=3a0⊕a1⊕a2⊕2a3
- Arithmetic rules:
  - xtime(a) = {a[6:0],1'b0} ⊕ (a[7] ? 8'h1B : 0).
  - 3a = xtime(a)⊕a.
  - All intermediate values are 8-bit. No unreduced products are stored.
- in_data and inv_i changes after the accept edge have no effect.
- out_valid without out_ready: out_data holds indefinitely. The engine does not accept new input.

## Timing
- Reset values, applied asynchronously: state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, cnt=0.
- Latency: if the accept edge is E0, out_valid rises after edge EK (K clocks).
- Throughput: one block every K+2 clocks with out_ready held at 1:
  - K BUSY clocks.
  - 1 DONE clock.
  - 1 IDLE clock.
- COLS_PER_CYCLE=4 gives K=1. The combinational path is one full-state matrix pass.
- Reset mid-operation (BUSY or DONE):
  - Outputs return to reset values immediately.
  - The in-flight block is discarded.
  - in_ready=1 in the first cycle after rst_n deasserts.
- in_valid held high through BUSY/DONE is ignored and is accepted on the next IDLE cycle.

## Configuration
- MIX_COLUMNS_INV_EN defined:
  - The inv_i port exists.
  - inv_i=1 latched at accept selects InvMixColumns with matrix rows {0e,0b,0d,09}, rotated per row.
  - Multiples are built from the xtime chain: 9=8⊕1, b=8⊕2⊕1, d=8⊕4⊕1, e=8⊕4⊕2.
  - Latency is identical to forward.
- MIX_COLUMNS_INV_EN undefined:
  - No inv_i port and no inverse logic.
  - Forward only.

## Test plan
- Reset check: assert rst_n=0 -> in_ready=1, out_valid=0, out_data=0, busy=0. Repeat with reset asserted mid-BUSY: the block is discarded and no out_valid follows.
- FIPS-197 columns, COLS_PER_CYCLE=1: in_data=db135345_f20a225c_01010101_c6c6c6c6 -> out_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid rising 4 clocks after the accept edge.
- Edge bytes: d4d4d4d5_2d26314c_00000000_ffffffff -> d5d5d7d6_4d7ebdf8_00000000_ffffffff. Run for COLS_PER_CYCLE 1, 2 and 4 and check latency 4, 2 and 1 respectively.
- Backpressure: hold out_ready=0 for 10 clocks in DONE -> out_data stable, in_ready=0, a second in_valid is not accepted. Raise out_ready -> next block is accepted one clock later.
- Inverse (MIX_COLUMNS_INV_EN): inv_i=1 with 8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> db135345_f20a225c_01010101_c6c6c6c6. Then 200 random states run forward then inverse must round-trip exactly.

Source files
------------

// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for mix_columns_seq: state input channel and result output channel.
// The master drives the input and consumes the result; the slave is the engine.
interface mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns engine, COLS_PER_CYCLE columns per clock (IDLE/BUSY/DONE).
// Define MIX_COLUMNS_INV_EN to add the inv_i port and InvMixColumns datapath.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mix_columns_seq_if.slave  bus,
    output logic              busy
`ifdef MIX_COLUMNS_INV_EN
    ,
    input  logic              inv_i
`endif
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam int K = 4 / COLS_PER_CYCLE;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3, m0, m1, m2, m3;
        a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
        m0 = xtime(a0); m1 = xtime(a1); m2 = xtime(a2); m3 = xtime(a3);
        return {m0 ^ (m1 ^ a1) ^ a2 ^ a3,
                a0 ^ m1 ^ (m2 ^ a2) ^ a3,
                a0 ^ a1 ^ m2 ^ (m3 ^ a3),
                (m0 ^ a0) ^ a1 ^ a2 ^ m3};
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    // Multiples 9/b/d/e assembled from the x2, x4, x8 xtime chain of each byte.
    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31 - 8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction
`endif

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] data_q, data_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;
`ifdef MIX_COLUMNS_INV_EN
    logic         inv_q, inv_d;
`endif

    logic [1:0]   col_idx [COLS_PER_CYCLE];
    logic [31:0]  col_out [COLS_PER_CYCLE];

    // Columns handled this clock: [cnt*COLS_PER_CYCLE +: COLS_PER_CYCLE], read from the result register.
    for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
        logic [31:0] col_in;
        assign col_idx[gi] = 2'(int'(cnt_q) * COLS_PER_CYCLE + gi);
        assign col_in      = data_q[127 - 32*int'(col_idx[gi]) -: 32];
`ifdef MIX_COLUMNS_INV_EN
        assign col_out[gi] = inv_q ? mix_inv(col_in) : mix_fwd(col_in);
`else
        assign col_out[gi] = mix_fwd(col_in);
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
`ifdef MIX_COLUMNS_INV_EN
        inv_d       = inv_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    data_d     = bus.in_data;
                    cnt_d      = 2'd0;
                    state_d    = BUSY;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
`ifdef MIX_COLUMNS_INV_EN
                    inv_d      = inv_i;
`endif
                end
            end
            BUSY: begin
                for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                    data_d[127 - 32*int'(col_idx[i]) -: 32] = col_out[i];
                end
                if (cnt_q == 2'(K - 1)) begin
                    state_d     = DONE;
                    cnt_d       = 2'd0;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                // in_ready returns only in IDLE, so a new block can never overlap the handoff.
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = 2'd0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            data_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef MIX_COLUMNS_INV_EN
            inv_q       <= inv_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: three instances with COLS_PER_CYCLE 1, 2 and 4.
// With MIX_COLUMNS_INV_EN defined it also exercises the inverse and forward/inverse round trips.
module tb_mix_columns_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mix_columns_seq_if bus [3] ();

    logic         in_valid_t  [3];
    logic [127:0] in_data_t   [3];
    logic         out_ready_t [3];
    logic         in_ready_w  [3];
    logic         out_valid_w [3];
    logic [127:0] out_data_w  [3];
    logic         busy_w      [3];
`ifdef MIX_COLUMNS_INV_EN
    logic         inv_t       [3];
`endif

    localparam logic [127:0] FIPS_IN   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] EDGE_IN   = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] EDGE_OUT  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] ROUND_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] ROUND_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int CPC = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
        assign bus[gi].in_valid  = in_valid_t[gi];
        assign bus[gi].in_data   = in_data_t[gi];
        assign bus[gi].out_ready = out_ready_t[gi];
        assign in_ready_w[gi]    = bus[gi].in_ready;
        assign out_valid_w[gi]   = bus[gi].out_valid;
        assign out_data_w[gi]    = bus[gi].out_data;

        mix_columns_seq #(.COLS_PER_CYCLE(CPC)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus[gi]),
            .busy  (busy_w[gi])
`ifdef MIX_COLUMNS_INV_EN
            ,
            .inv_i (inv_t[gi])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int s);
        return (s == 0) ? 4 : ((s == 1) ? 2 : 1);
    endfunction

    // One block through instance s; returns the result and optionally checks it against exp.
    task automatic run_block(input int s, input logic [127:0] din, input logic [127:0] exp,
                             input bit check_data, input logic inv, input string tag,
                             output logic [127:0] got);
        int n;
        bit seen;
        n = 0;
        @(negedge clk);
        while (!in_ready_w[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 128'(in_ready_w[s]), 128'd1);
        in_valid_t[s] = 1'b1;
        in_data_t[s]  = din;
`ifdef MIX_COLUMNS_INV_EN
        inv_t[s]      = inv;
`endif
        @(posedge clk);
        #1;
        in_valid_t[s] = 1'b0;
        in_data_t[s]  = ~din;
`ifdef MIX_COLUMNS_INV_EN
        inv_t[s]      = ~inv;
`endif
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            #1;
            seen = out_valid_w[s];
        end
        chk({tag, "_latency"}, 128'(n), 128'(lat_of(s)));
        got = out_data_w[s];
        if (check_data) chk({tag, "_data"}, got, exp);
        $display("xfer %s inst=%0d inv=%0d in=%h out=%h latency=%0d", tag, s, inv, din, got, n);
        if (out_ready_t[s]) begin
            @(posedge clk);
            #1;
            chk({tag, "_idle_valid"}, 128'(out_valid_w[s]), 128'd0);
            chk({tag, "_idle_ready"}, 128'(in_ready_w[s]), 128'd1);
        end
    endtask

    initial begin
        logic [127:0] got;
        logic [127:0] fwd;
        logic [127:0] rnd;
        int n;
        bit seen;
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        for (int s = 0; s < 3; s++) begin
            in_valid_t[s]  = 1'b0;
            in_data_t[s]   = '0;
            out_ready_t[s] = 1'b1;
`ifdef MIX_COLUMNS_INV_EN
            inv_t[s]       = 1'b0;
`endif
        end

        // Asynchronous reset values
        #1 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst%0d_in_ready", s), 128'(in_ready_w[s]), 128'd1);
            chk($sformatf("rst%0d_out_valid", s), 128'(out_valid_w[s]), 128'd0);
            chk($sformatf("rst%0d_out_data", s), out_data_w[s], 128'd0);
            chk($sformatf("rst%0d_busy", s), 128'(busy_w[s]), 128'd0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Known-answer vectors
        run_block(0, FIPS_IN, FIPS_OUT, 1'b1, 1'b0, "fips_c1", got);
        run_block(0, EDGE_IN, EDGE_OUT, 1'b1, 1'b0, "edge_c1", got);
        run_block(1, EDGE_IN, EDGE_OUT, 1'b1, 1'b0, "edge_c2", got);
        run_block(2, EDGE_IN, EDGE_OUT, 1'b1, 1'b0, "edge_c4", got);
        run_block(1, ROUND_IN, ROUND_OUT, 1'b1, 1'b0, "round_c2", got);
        run_block(2, ROUND_IN, ROUND_OUT, 1'b1, 1'b0, "round_c4", got);

        // Backpressure: result held in DONE, second request ignored until IDLE
        out_ready_t[0] = 1'b0;
        run_block(0, EDGE_IN, EDGE_OUT, 1'b1, 1'b0, "bp_first", got);
        in_valid_t[0] = 1'b1;
        in_data_t[0]  = FIPS_IN;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_data", out_data_w[0], EDGE_OUT);
            chk("bp_hold_valid", 128'(out_valid_w[0]), 128'd1);
            chk("bp_hold_in_ready", 128'(in_ready_w[0]), 128'd0);
            chk("bp_hold_busy", 128'(busy_w[0]), 128'd1);
        end
        @(negedge clk);
        out_ready_t[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 128'(out_valid_w[0]), 128'd0);
        chk("bp_release_in_ready", 128'(in_ready_w[0]), 128'd1);
        @(posedge clk);
        #1;
        chk("bp_second_accept_busy", 128'(busy_w[0]), 128'd1);
        chk("bp_second_accept_ready", 128'(in_ready_w[0]), 128'd0);
        in_valid_t[0] = 1'b0;
        in_data_t[0]  = '0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            #1;
            seen = out_valid_w[0];
        end
        chk("bp_second_latency", 128'(n), 128'd4);
        chk("bp_second_data", out_data_w[0], FIPS_OUT);
        $display("xfer bp_second inst=0 inv=0 in=%h out=%h latency=%0d", FIPS_IN, out_data_w[0], n);
        repeat (2) @(posedge clk);

        // Reset asserted mid-BUSY discards the block
        @(negedge clk);
        in_valid_t[0] = 1'b1;
        in_data_t[0]  = FIPS_IN;
        @(posedge clk);
        #1;
        in_valid_t[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy_before", 128'(busy_w[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 128'(busy_w[0]), 128'd0);
        chk("midrst_in_ready", 128'(in_ready_w[0]), 128'd1);
        chk("midrst_out_valid", 128'(out_valid_w[0]), 128'd0);
        chk("midrst_out_data", out_data_w[0], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_no_valid", 128'(out_valid_w[0]), 128'd0);
            chk("midrst_idle_ready", 128'(in_ready_w[0]), 128'd1);
        end
        $display("xfer midrst inst=0 block discarded");

`ifdef MIX_COLUMNS_INV_EN
        // Inverse known answer, then forward/inverse round trips on random states
        run_block(0, FIPS_OUT, FIPS_IN, 1'b1, 1'b1, "inv_fips_c1", got);
        run_block(2, ROUND_OUT, ROUND_IN, 1'b1, 1'b1, "inv_round_c4", got);
        for (int i = 0; i < 200; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            run_block(i % 3, rnd, '0, 1'b0, 1'b0, "rt_fwd", fwd);
            run_block(i % 3, fwd, rnd, 1'b1, 1'b1, "rt_inv", got);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
